wac_dispatch: RTL and testbench

- Parametrised command dispatcher for the WAC board.
- Accepts one command at a time over a valid/ready handshake and latches it.
- Launches exactly one peripheral transaction per command: DAC write, reference-mux set, digipot write, sequencer run, or N-sample ADC burst on one of N_ADC channels.
- Waits for that peripheral's completion before accepting the next command; forwards ADC samples with a channel tag. Sits between the host interface and the existing DAC/digipot/ADC/sequencer controllers.

---
 rtl/wac_dispatch.sv | 148 ++++++++++++++
 tb/tb_wac_dispatch.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wac_dispatch.sv
// wac_dispatch: one-at-a-time command dispatcher for the WAC DAC/mux/digipot/sequencer/ADC controllers.
// Define WAC_TIMEOUT_EN to bound WAIT with a TMO_W-bit no-progress timeout (err_code 2).
module wac_dispatch #(
    parameter int N_ADC   = 2,
    parameter int ADC_W   = 12,
    parameter int CONF_W  = 16,
    parameter int NSAMP_W = 12,
    parameter int TMO_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [7:0]             cmd_word,
    input  logic [CONF_W-1:0]      conf_word,
    input  logic [NSAMP_W-1:0]     n_samples,
    output logic [2:0]             mux_ref,
    output logic                   mux_dac_en,
    output logic                   dac_start,
    output logic [15:0]            dac_data,
    input  logic                   dac_done,
    output logic                   dpot_start,
    output logic [1:0]             dpot_sel,
    output logic [7:0]             dpot_data,
    input  logic                   dpot_done,
    output logic [N_ADC-1:0]       adc_start,
    output logic                   adc_mode,
    output logic [NSAMP_W-1:0]     adc_n,
    input  logic [N_ADC-1:0]       adc_ready,
    input  logic [N_ADC*ADC_W-1:0] adc_data,
    output logic                   seq_start,
    output logic [1:0]             seq_mode,
    input  logic                   seq_done,
    output logic                   smp_valid,
    output logic [ADC_W-1:0]       smp_data,
    output logic [3:0]             smp_chan,
    output logic                   busy,
    output logic                   err,
    output logic [1:0]             err_code
);
    localparam logic [3:0] OP_DAC = 4'h1, OP_MUX = 4'h2, OP_DPOT = 4'h3, OP_SEQ = 4'h4, OP_ADC = 4'h9;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
    state_t state, nextState;
    logic [3:0] op, arg, confLo;
    logic [NSAMP_W-1:0] nLat, cnt;
    logic accept, isAdc, badCmd, launch, sampleHit, doneHit, adcDone, tmoHit;
    logic [N_ADC-1:0] rdyShift;
    logic [N_ADC*ADC_W-1:0] dataShift;

    function automatic logic chanOk(input logic [3:0] c);
        return int'(c) < N_ADC;
    endfunction

    assign accept    = cmd_valid && state == IDLE;
    assign isAdc     = op == OP_ADC;
    assign badCmd    = !(op inside {OP_DAC, OP_MUX, OP_DPOT, OP_SEQ} || (isAdc && chanOk(arg)));
    assign launch    = state == LAUNCH && !badCmd;
    assign rdyShift  = adc_ready >> arg;
    assign dataShift = adc_data >> (arg * ADC_W);
    assign sampleHit = state == WAIT && isAdc && rdyShift[0] && cnt != nLat;
    assign adcDone   = isAdc && cnt == nLat;
    assign doneHit   = state == WAIT && ((op == OP_DAC && dac_done) || (op == OP_DPOT && dpot_done) ||
                                         (op == OP_SEQ && seq_done));

`ifdef WAC_TIMEOUT_EN
    logic [TMO_W-1:0] tmo;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) tmo <= '0;
        else tmo <= (state != WAIT || sampleHit || doneHit) ? '0 : tmo + 1'b1;
    assign tmoHit = state == WAIT && &tmo && !(sampleHit || doneHit || adcDone);
`else
    assign tmoHit = 1'b0 & (TMO_W > 0);
`endif

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    nextState = cmd_valid ? LAUNCH : IDLE;
            LAUNCH:  nextState = (badCmd || op == OP_MUX) ? DONE : WAIT;
            WAIT:    nextState = (doneHit || adcDone || tmoHit) ? DONE : WAIT;
            default: nextState = IDLE;
        endcase
    end

    assign cmd_ready  = state == IDLE;
    assign busy       = state != IDLE;
    assign dac_start  = launch && op == OP_DAC;
    assign dpot_start = launch && op == OP_DPOT;
    assign seq_start  = launch && op == OP_SEQ;
    assign adc_start  = (launch && isAdc) ? N_ADC'(1) << arg : '0;
    assign err        = (state == LAUNCH && badCmd) || tmoHit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            op         <= '0;
            arg        <= '0;
            confLo     <= '0;
            nLat       <= '0;
            cnt        <= '0;
            mux_ref    <= 3'b111;
            mux_dac_en <= 1'b1;
            dac_data   <= '0;
            dpot_sel   <= '0;
            dpot_data  <= '0;
            seq_mode   <= '0;
            adc_mode   <= 1'b0;
            adc_n      <= '0;
            smp_valid  <= 1'b0;
            smp_data   <= '0;
            smp_chan   <= '0;
            err_code   <= '0;
        end else begin
            state     <= nextState;
            smp_valid <= 1'b0;
            if (accept) begin
                op       <= cmd_word[3:0];
                arg      <= cmd_word[7:4];
                confLo   <= conf_word[3:0];
                nLat     <= n_samples;
                cnt      <= '0;
                err_code <= '0;
                if (cmd_word[3:0] == OP_DAC) dac_data <= conf_word[15:0];
                if (cmd_word[3:0] == OP_DPOT) begin
                    dpot_sel  <= conf_word[9:8];
                    dpot_data <= conf_word[7:0];
                end
                if (cmd_word[3:0] == OP_SEQ) seq_mode <= cmd_word[5:4];
                // ADC launch data only changes when the channel is real
                if (cmd_word[3:0] == OP_ADC && chanOk(cmd_word[7:4])) begin
                    adc_mode <= conf_word[0];
                    adc_n    <= n_samples;
                end
            end
            if (state == LAUNCH && op == OP_MUX) begin
                mux_ref    <= confLo[2:0];
                mux_dac_en <= confLo[3];
            end
            if (err) err_code <= tmoHit ? 2'd2 : 2'd1;
            if (sampleHit) begin
                smp_valid <= 1'b1;
                smp_data  <= dataShift[ADC_W-1:0];
                smp_chan  <= arg;
                cnt       <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_wac_dispatch.sv
// tb_wac_dispatch: randomized command stream against a transaction-level model of wac_dispatch.
module tb_wac_dispatch;
    localparam int N_ADC = 2, ADC_W = 12, CONF_W = 16, NSAMP_W = 12, TMO_W = 16;
    logic clk = 0, rst_n = 0;
    logic cmd_valid = 0, cmd_ready;
    logic [7:0] cmd_word = 0;
    logic [CONF_W-1:0] conf_word = 0;
    logic [NSAMP_W-1:0] n_samples = 0;
    logic [2:0] mux_ref;
    logic mux_dac_en, dac_start, dac_done = 0, dpot_start, dpot_done = 0, seq_start, seq_done = 0;
    logic [15:0] dac_data;
    logic [1:0] dpot_sel, seq_mode, err_code;
    logic [7:0] dpot_data;
    logic [N_ADC-1:0] adc_start, adc_ready = 0;
    logic adc_mode, smp_valid, busy, err;
    logic [NSAMP_W-1:0] adc_n;
    logic [N_ADC*ADC_W-1:0] adc_data = 0;
    logic [ADC_W-1:0] smp_data;
    logic [3:0] smp_chan;

    wac_dispatch #(.N_ADC(N_ADC), .ADC_W(ADC_W), .CONF_W(CONF_W), .NSAMP_W(NSAMP_W), .TMO_W(TMO_W)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_word(cmd_word),
        .conf_word(conf_word), .n_samples(n_samples), .mux_ref(mux_ref), .mux_dac_en(mux_dac_en),
        .dac_start(dac_start), .dac_data(dac_data), .dac_done(dac_done), .dpot_start(dpot_start),
        .dpot_sel(dpot_sel), .dpot_data(dpot_data), .dpot_done(dpot_done), .adc_start(adc_start),
        .adc_mode(adc_mode), .adc_n(adc_n), .adc_ready(adc_ready), .adc_data(adc_data),
        .seq_start(seq_start), .seq_mode(seq_mode), .seq_done(seq_done), .smp_valid(smp_valid),
        .smp_data(smp_data), .smp_chan(smp_chan), .busy(busy), .err(err), .err_code(err_code));

    always #5 clk = ~clk;

    int errs = 0, checks = 0;
    logic [2:0] mMuxRef;
    logic mMuxEn, mAdcMode;
    logic [15:0] mDac;
    logic [1:0] mDpotSel, mSeq, mErr;
    logic [7:0] mDpotData;
    logic [NSAMP_W-1:0] mAdcN;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic modelReset();
        mMuxRef = 3'b111; mMuxEn = 1; mDac = 0; mDpotSel = 0; mDpotData = 0;
        mSeq = 0; mAdcMode = 0; mAdcN = 0; mErr = 0;
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_ctrl"}, {cmd_ready, busy, err, err_code, mux_ref, mux_dac_en, dac_start, dpot_start,
                               seq_start, adc_start, smp_valid}, {1'b1, 1'b0, 1'b0, 2'd0, 3'b111, 1'b1, 5'd0, 1'b0});
        check({tag, "_data"}, {dac_data, dpot_sel, dpot_data, seq_mode, adc_mode, adc_n, smp_data, smp_chan}, 64'd0);
    endtask

    task automatic checkHeld(input string tag);
        check(tag, {mux_ref, mux_dac_en, dac_data, dpot_sel, dpot_data, seq_mode, adc_mode, adc_n, err_code},
              {mMuxRef, mMuxEn, mDac, mDpotSel, mDpotData, mSeq, mAdcMode, mAdcN, mErr});
    endtask

    task automatic clearPeriph();
        dac_done = 0; dpot_done = 0; seq_done = 0; adc_ready = 0;
    endtask

    task automatic runCmd(input logic [7:0] cw, input logic [15:0] cf, input logic [NSAMP_W-1:0] n);
        logic [3:0] op, ch;
        logic [N_ADC-1:0] expStart, rdy;
        logic [N_ADC*ADC_W-1:0] dat;
        logic [ADC_W-1:0] q[$];
        bit ok;
        int acc, got, d;
        op = cw[3:0];
        ch = cw[7:4];
        ok = (op inside {4'h1, 4'h2, 4'h3, 4'h4}) || (op == 4'h9 && int'(ch) < N_ADC);
        check("idle_ready", {cmd_ready, busy}, 2'b10);
        cmd_valid = 1; cmd_word = cw; conf_word = cf; n_samples = n;
        step();
        cmd_valid = 0; cmd_word = 8'($urandom); conf_word = 16'($urandom); n_samples = NSAMP_W'($urandom);
        mErr = ok ? 2'd0 : 2'd1;
        case (op)
            4'h1: mDac = cf;
            4'h2: begin mMuxRef = cf[2:0]; mMuxEn = cf[3]; end
            4'h3: begin mDpotSel = cf[9:8]; mDpotData = cf[7:0]; end
            4'h4: mSeq = cw[5:4];
            4'h9: if (ok) begin mAdcMode = cf[0]; mAdcN = n; end
            default: ;
        endcase
        expStart = (ok && op == 4'h9) ? N_ADC'(1) << ch : '0;
        check("launch_strobes", {dac_start, dpot_start, seq_start, adc_start, err, busy, cmd_ready, err_code},
              {op == 4'h1, op == 4'h3, op == 4'h4, expStart, !ok, 1'b1, 1'b0, 2'd0});
        check("launch_data", {dac_data, dpot_sel, dpot_data, seq_mode, adc_mode, adc_n},
              {mDac, mDpotSel, mDpotData, mSeq, mAdcMode, mAdcN});
        // completions presented during LAUNCH must not count
        dac_done = 1; dpot_done = 1; seq_done = 1; adc_ready = '1; adc_data = 24'($urandom);
        if (!ok || op == 4'h2) begin
            step();
            clearPeriph();
            check("done_state", {busy, cmd_ready, err, err_code, mux_ref, mux_dac_en, dac_start, dpot_start,
                                 seq_start, adc_start}, {1'b1, 1'b0, 1'b0, mErr, mMuxRef, mMuxEn, 3'd0, 2'd0});
            step();
        end else if (op == 4'h9) begin
            acc = 0; got = 0;
            for (int g = 0; g < 300; g++) begin
                step();
                if (smp_valid) begin
                    if (q.size() == 0) check("smp_extra", 1, 0);
                    else check("smp", {smp_chan, smp_data}, {ch, q.pop_front()});
                    got++;
                end
                if (cmd_ready) break;
                rdy = N_ADC'($urandom); dat = 24'($urandom);
                adc_ready = rdy; adc_data = dat;
                if (rdy[ch] && acc < int'(n)) begin
                    q.push_back(dat[int'(ch)*ADC_W +: ADC_W]);
                    acc++;
                end
            end
            clearPeriph();
            check("adc_count", got, n);
        end else begin
            d = $urandom_range(2, 5);
            for (int i = 0; i < d; i++) begin
                step();
                check("wait_hold", {busy, cmd_ready}, 2'b10);
                dac_done = op != 4'h1 && $urandom_range(0, 1) == 1;
                dpot_done = op != 4'h3 && $urandom_range(0, 1) == 1;
                seq_done = op != 4'h4 && $urandom_range(0, 1) == 1;
                adc_ready = N_ADC'($urandom);
            end
            step();
            clearPeriph();
            dac_done = op == 4'h1; dpot_done = op == 4'h3; seq_done = op == 4'h4;
            step();
            clearPeriph();
            check("done_busy", {busy, cmd_ready, err}, 3'b100);
            step();
        end
        check("back_idle", {cmd_ready, busy, smp_valid}, 3'b100);
        checkHeld("held_regs");
    endtask

    initial begin
        logic [3:0] op;
        modelReset();
        repeat (3) step();
        checkReset("reset");
        rst_n = 1;
        step();
        runCmd(8'h02, 16'h0005, 0);
        runCmd(8'h01, 16'hA55A, 0);
        runCmd(8'h19, 16'h0001, 3);
        runCmd(8'h29, 16'h1234, 2);
        runCmd(8'h07, 16'h4321, 0);
        runCmd(8'h09, 16'h0000, 0);
        for (int k = 0; k < 60; k++) begin
            case ($urandom_range(0, 6))
                0: op = 4'h1;
                1: op = 4'h2;
                2: op = 4'h3;
                3: op = 4'h4;
                4, 5: op = 4'h9;
                default: do op = 4'($urandom_range(0, 15)); while (op inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h9});
            endcase
            runCmd({op == 4'h9 ? 4'($urandom_range(0, 3)) : 4'($urandom), op}, 16'($urandom),
                   NSAMP_W'($urandom_range(0, 5)));
        end
        cmd_valid = 1; cmd_word = 8'h19; n_samples = 3;
        step();
        cmd_valid = 0;
        step();
        adc_ready = 2'b10; adc_data = 24'h5A5123;
        step();
        adc_ready = 0;
        check("pre_reset_smp", {smp_valid, smp_chan, smp_data}, {1'b1, 4'd1, 12'h5A5});
        rst_n = 0;
        #1;
        checkReset("mid_reset");
        modelReset();
        adc_ready = '1;
        step();
        step();
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("post_reset_quiet", {smp_valid, adc_start, busy, cmd_ready}, {1'b0, 2'b00, 1'b0, 1'b1});
        end
        adc_ready = 0;
        checkHeld("post_reset_regs");
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
